fifo_sync_lvl: RTL and testbench
================================

FIFO_SYNC_LVL -- requirements
Module: fifo_sync_lvl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, storage depth 2**DEPTH_LOG2 words; legal range 1..12.
REQ-003 SHALL have parameter AF_THRESH, default 6, almost_full asserts when count >= AF_THRESH; legal range 1..2**DEPTH_LOG2.
REQ-004 SHALL have parameter AE_THRESH, default 1, almost_empty asserts when count <= AE_THRESH; legal range 0..2**DEPTH_LOG2-1.
REQ-005 SHALL have parameter FWFT, default 1: 1 = show-ahead read, 0 = registered read.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 flush  input  1  synchronous empty request.
REQ-009 winc  input  1  write request.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 rinc  input  1  read request.
REQ-012 rdata  output  WIDTH  read data.
REQ-013 rvalid  output  1  FWFT=1: equals ~rempty; FWFT=0: one-cycle pulse marking rdata updated.
REQ-014 wfull, rempty  output  1 each  full / empty flags.
REQ-015 almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 SHALL keep write and read pointers of DEPTH_LOG2+1 bits; MSB is wrap bit, low bits address storage; pointers wrap modulo 2**(DEPTH_LOG2+1).
REQ-019 SHALL accept a write iff winc & ~wfull & ~flush; accepted write stores wdata at write address and increments write pointer.
REQ-020 SHALL accept a read iff rinc & ~rempty & ~flush; accepted read increments read pointer.
REQ-021 SHALL accept a simultaneous write and read in the same cycle when both conditions hold, count unchanged; write while full with read SHALL be rejected (full evaluated before the edge).
REQ-022 count SHALL equal write pointer minus read pointer (modulo 2**(DEPTH_LOG2+1)); rempty = (count==0); wfull = (count==2**DEPTH_LOG2); all flags decoded from registered state only, no combinational path from winc/rinc.
REQ-023 FWFT=1: rdata SHALL combinationally present the word at read address; value undefined when rempty.
REQ-024 FWFT=0: on an accepted read, rdata SHALL register the word at the pre-increment read address and rvalid SHALL pulse high the following cycle (one-cycle latency); otherwise rdata holds and rvalid is 0.
REQ-025 overflow SHALL set on winc & wfull & ~flush and underflow on rinc & rempty & ~flush; rejected request changes no other state; flags stay set until flush or rst.
REQ-026 flush SHALL, on the next edge, zero both pointers, clear overflow and underflow, clear rvalid, and discard any concurrent winc/rinc; rdata holds its value in FWFT=0; storage contents are not cleared.
REQ-027 Storage SHALL not be reset; only pointers, flags and output registers are reset.

Reset
REQ-028 While rst is high, pointers, count, rvalid, overflow, underflow and (FWFT=0) rdata SHALL be 0 immediately, without waiting for clk.
REQ-029 During reset: rempty=1, wfull=0, almost_empty=1, almost_full=0.
REQ-030 rst asserted mid-operation SHALL discard all stored words; first edge after deassertion accepts requests normally.

Verification (WIDTH=8, DEPTH_LOG2=3, AF_THRESH=6, AE_THRESH=1)
REQ-031 Fill: 8 writes 0x10..0x17, no reads -> count steps 1..8; almost_empty falls at count 2; almost_full rises at count 6; wfull at 8; 9th write 0x18 sets overflow, count stays 8.
REQ-032 Drain FWFT=1 after fill: 8 reads -> rdata 0x10..0x17 in order, rempty after 8th; 9th read sets underflow, pointers unchanged.
REQ-033 FWFT=0: write 0xA5, read next cycle -> rvalid pulses one cycle after read with rdata=0xA5, rdata holds 0xA5 afterwards.
REQ-034 Wrap: 20 cycles of simultaneous write/read at count 4 -> count stays 4, data order preserved across pointer wrap, no error flags.
REQ-035 Flush with count=5, overflow set, winc=rinc=1 -> next cycle count=0, rempty=1, overflow=0, write not stored.
REQ-036 Async reset pulse between clock edges at count=3 -> count=0, rempty=1 before next edge; subsequent write 0x3C then read returns 0x3C.

Source files
------------

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// FWFT selects show-ahead (combinational) or registered (one-cycle latency) read data.
module fifo_sync_lvl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  winc,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  rinc,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_THRESH);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] waddr;
    logic [DEPTH_LOG2-1:0] raddr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign waddr = wptr[DEPTH_LOG2-1:0];
    assign raddr = rptr[DEPTH_LOG2-1:0];

    // All flags come from the registered pointers only, never from winc/rinc.
    assign count        = wptr - rptr;
    assign rempty       = (count == '0);
    assign wfull        = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign wr_ok = winc & ~wfull  & ~flush;
    assign rd_ok = rinc & ~rempty & ~flush;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky error flags: only flush or reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc & wfull) begin
                overflow <= 1'b1;
            end
            if (rinc & rempty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rdata  = mem[raddr];
            assign rvalid = ~rempty;
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            // rdata holds across flush; only an accepted read updates it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (rd_ok) begin
                    rdata_q  <= mem[raddr];
                    rvalid_q <= 1'b1;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Drives a show-ahead and a registered-read FIFO with identical stimulus and
// compares both against a queue-based reference model.
module tb_fifo_sync_lvl;

    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata_a, rdata_b;
    logic       rvalid_a, rvalid_b;
    logic       wfull_a, wfull_b, rempty_a, rempty_b;
    logic       af_a, af_b, ae_a, ae_b;
    logic [3:0] count_a, count_b;
    logic       ov_a, ov_b, un_a, un_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       exp_ov = 1'b0;
    logic       exp_un = 1'b0;
    logic [7:0] exp_rdata_b = 8'h00;
    logic       exp_rvalid_b = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_lvl #(.WIDTH(8), .DEPTH_LOG2(3), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata_a), .rvalid(rvalid_a), .wfull(wfull_a), .rempty(rempty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
        .overflow(ov_a), .underflow(un_a)
    );

    fifo_sync_lvl #(.WIDTH(8), .DEPTH_LOG2(3), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata_b), .rvalid(rvalid_b), .wfull(wfull_b), .rempty(rempty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
        .overflow(ov_b), .underflow(un_b)
    );

    task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_ov       = 1'b0;
        exp_un       = 1'b0;
        exp_rdata_b  = 8'h00;
        exp_rvalid_b = 1'b0;
    endtask

    // Reference behaviour of one clock edge, evaluated on the pre-edge state.
    task automatic model_step();
        bit full  = (q.size() == DEPTH);
        bit empty = (q.size() == 0);
        if (flush) begin
            q.delete();
            exp_ov       = 1'b0;
            exp_un       = 1'b0;
            exp_rvalid_b = 1'b0;
        end else begin
            if (winc && full)  exp_ov = 1'b1;
            if (rinc && empty) exp_un = 1'b1;
            if (rinc && !empty) begin
                exp_rdata_b  = q.pop_front();
                exp_rvalid_b = 1'b1;
            end else begin
                exp_rvalid_b = 1'b0;
            end
            if (winc && !full) q.push_back(wdata);
        end
    endtask

    task automatic check_output(input string tag);
        int n = q.size();
        chk(tag, "count_a",  32'(count_a),  32'(n));
        chk(tag, "count_b",  32'(count_b),  32'(n));
        chk(tag, "rempty",   32'(rempty_a), 32'(n == 0));
        chk(tag, "wfull",    32'(wfull_a),  32'(n == DEPTH));
        chk(tag, "afull",    32'(af_a),     32'(n >= AF));
        chk(tag, "aempty",   32'(ae_a),     32'(n <= AE));
        chk(tag, "overflow", 32'(ov_a),     32'(exp_ov));
        chk(tag, "underflw", 32'(un_a),     32'(exp_un));
        chk(tag, "ovf_b",    32'(ov_b),     32'(exp_ov));
        chk(tag, "rvalid_a", 32'(rvalid_a), 32'(n != 0));
        chk(tag, "rvalid_b", 32'(rvalid_b), 32'(exp_rvalid_b));
        chk(tag, "rdata_b",  32'(rdata_b),  32'(exp_rdata_b));
        if (n != 0) chk(tag, "rdata_a", 32'(rdata_a), 32'(q[0]));
    endtask

    task automatic apply_stimulus(input logic w, input logic r, input logic f,
                                  input logic [7:0] d, input string tag);
        winc  = w;
        rinc  = r;
        flush = f;
        wdata = d;
        model_step();
        @(posedge clk);
        #1;
        winc  = 1'b0;
        rinc  = 1'b0;
        flush = 1'b0;
        check_output(tag);
    endtask

    initial begin
        #2;
        model_reset();
        check_output("reset");
        chk("reset", "rdata_b_zero", 32'(rdata_b), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then one write too many
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), "fill");
            chk("fill", "count_step", 32'(count_a), 32'(i + 1));
        end
        chk("fill", "wfull_at_8", 32'(wfull_a), 32'h1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h18, "overflow");
        chk("overflow", "ov_set", 32'(ov_a), 32'h1);

        // Drain in order, then one read too many
        for (int i = 0; i < 8; i++) begin
            chk("drain", "rdata_seq", 32'(rdata_a), 32'(8'h10 + i));
            apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, "drain");
        end
        chk("drain", "rempty_end", 32'(rempty_a), 32'h1);
        chk("drain", "rdata_b_last", 32'(rdata_b), 32'h17);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, "underflow");
        chk("underflow", "un_set", 32'(un_a), 32'h1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "flush_flags");

        // Registered read latency
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'hA5, "a5_write");
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, "a5_read");
        chk("a5_read", "rvalid_pulse", 32'(rvalid_b), 32'h1);
        chk("a5_read", "rdata_a5", 32'(rdata_b), 32'hA5);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, "a5_hold");
        chk("a5_hold", "rvalid_low", 32'(rvalid_b), 32'h0);
        chk("a5_hold", "rdata_hold", 32'(rdata_b), 32'hA5);

        // Simultaneous write/read at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom), "wrap_pre");
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 8'($urandom), "wrap");
            chk("wrap", "count4", 32'(count_a), 32'h4);
        end
        chk("wrap", "no_errors", 32'({ov_a, un_a}), 32'h0);

        // Flush with overflow set and concurrent requests
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "flush_pre");
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom), "flush_fill");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, "flush_drain");
        chk("flush_setup", "count5", 32'(count_a), 32'h5);
        chk("flush_setup", "ov_set", 32'(ov_a), 32'h1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'hEE, "flush");
        chk("flush", "count0", 32'(count_a), 32'h0);
        chk("flush", "ov_clear", 32'(ov_a), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 24) == 0),
                           8'($urandom), "random");
        end

        // Asynchronous reset between edges
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, "areset_pre");
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 8'($urandom), "areset_fill");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("areset", "count0", 32'(count_a), 32'h0);
        chk("areset", "rempty", 32'(rempty_a), 32'h1);
        check_output("areset");
        #1;
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h3C, "post_reset_w");
        chk("post_reset", "rdata_a_3c", 32'(rdata_a), 32'h3C);
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00, "post_reset_r");
        chk("post_reset", "rdata_b_3c", 32'(rdata_b), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
